// File: rtl/spi_pkt_tx.sv
// SPI mode-0 packet transmitter: reads one package from the DAQ buffer and sends it behind a 16-bit frame-counter header.
// Optional CRC-8 trailer byte when SPI_PKT_CRC8_EN is defined.
module spi_pkt_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int PACKAGE_SIZE = 10,
    parameter int CLK_DIV      = 2,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  pkt_ready,
    output logic                  rd_en,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_out,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic [15:0]           frame_cnt
);

    // The IDLE cycle that samples pkt_ready also keeps cs_n high, so GAP itself
    // is one cycle shorter to keep cs_n high for GAP_CYCLES between back-to-back frames.
    localparam int GAP_LEN = (GAP_CYCLES > 1) ? (GAP_CYCLES - 1) : 1;
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int CNT_W   = $clog2(PACKAGE_SIZE + 1);
    localparam int GAP_W   = $clog2(GAP_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_GAP     = 3'd5
`ifdef SPI_PKT_CRC8_EN
        , ST_TRAILER = 3'd6
`endif
    } state_t;

    state_t             state_r;
    logic [7:0]         shreg_r;
    logic [DIV_W-1:0]   div_r;
    logic [3:0]         half_r;
    logic               hdr_lo_r;
    logic [CNT_W-1:0]   bytes_r;
    logic [GAP_W-1:0]   gap_r;
    logic               sclk_r;
    logic               cs_n_r;
    logic               mosi_r;
    logic               rd_en_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [15:0]        frame_cnt_r;
    logic               shifting_s;
    logic               tick_s;
    logic               byte_end_s;

`ifdef SPI_PKT_CRC8_EN
    logic [7:0]         crc_r;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    assign shifting_s = (state_r == ST_HDR) || (state_r == ST_SHIFT)
`ifdef SPI_PKT_CRC8_EN
                        || (state_r == ST_TRAILER)
`endif
                        ;
    assign tick_s     = (div_r == DIV_W'(CLK_DIV - 1));
    assign byte_end_s = shifting_s && tick_s && (half_r == 4'd15);

    assign sclk      = sclk_r;
    assign cs_n      = cs_n_r;
    assign mosi      = mosi_r;
    assign rd_en     = rd_en_r;
    assign busy      = busy_r;
    assign pkt_done  = done_r;
    assign pkt_err   = err_r;
    assign frame_cnt = frame_cnt_r;

    // Frame FSM, SCLK divider/bit shifter and all registered outputs.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shreg_r     <= 8'h00;
            div_r       <= '0;
            half_r      <= 4'd0;
            hdr_lo_r    <= 1'b0;
            bytes_r     <= '0;
            gap_r       <= '0;
            sclk_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            frame_cnt_r <= 16'h0000;
`ifdef SPI_PKT_CRC8_EN
            crc_r       <= 8'h00;
`endif
        end else begin
            rd_en_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;

            // Shift on the falling SCLK edge so the slave sees stable data on the rising edge.
            if (shifting_s) begin
                if (tick_s) begin
                    div_r  <= '0;
                    sclk_r <= ~sclk_r;
                    half_r <= half_r + 4'd1;
                    if (sclk_r) begin
                        shreg_r <= {shreg_r[6:0], 1'b0};
                        mosi_r  <= shreg_r[6];
                    end
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
            end else begin
                div_r  <= '0;
                half_r <= 4'd0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (pkt_ready) begin
                        state_r  <= ST_HDR;
                        cs_n_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        shreg_r  <= frame_cnt_r[15:8];
                        mosi_r   <= frame_cnt_r[15];
                        hdr_lo_r <= 1'b0;
                        bytes_r  <= '0;
`ifdef SPI_PKT_CRC8_EN
                        crc_r    <= crc8_upd(8'h00, frame_cnt_r[15:8]);
                    end else begin
                        crc_r    <= 8'h00;
`endif
                    end
                end
                ST_HDR: begin
                    if (byte_end_s) begin
                        if (!hdr_lo_r) begin
                            hdr_lo_r <= 1'b1;
                            shreg_r  <= frame_cnt_r[7:0];
                            mosi_r   <= frame_cnt_r[7];
`ifdef SPI_PKT_CRC8_EN
                            crc_r    <= crc8_upd(crc_r, frame_cnt_r[7:0]);
`endif
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (rd_out && (bytes_r < CNT_W'(PACKAGE_SIZE))) begin
                        err_r   <= 1'b1;
                        cs_n_r  <= 1'b1;
                        gap_r   <= '0;
                        state_r <= ST_GAP;
                    end else begin
                        rd_en_r <= 1'b1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (valid) begin
                        shreg_r <= dout[7:0];
                        mosi_r  <= dout[7];
                        state_r <= ST_SHIFT;
`ifdef SPI_PKT_CRC8_EN
                        crc_r   <= crc8_upd(crc_r, dout[7:0]);
`endif
                    end
                end
                ST_SHIFT: begin
                    if (byte_end_s) begin
                        bytes_r <= bytes_r + CNT_W'(1);
                        if (bytes_r == CNT_W'(PACKAGE_SIZE - 1)) begin
`ifdef SPI_PKT_CRC8_EN
                            shreg_r     <= crc_r;
                            mosi_r      <= crc_r[7];
                            state_r     <= ST_TRAILER;
`else
                            cs_n_r      <= 1'b1;
                            done_r      <= 1'b1;
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                            gap_r       <= '0;
                            state_r     <= ST_GAP;
`endif
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
`ifdef SPI_PKT_CRC8_EN
                ST_TRAILER: begin
                    if (byte_end_s) begin
                        cs_n_r      <= 1'b1;
                        done_r      <= 1'b1;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        gap_r       <= '0;
                        state_r     <= ST_GAP;
                    end
                end
`endif
                ST_GAP: begin
                    if (gap_r == GAP_W'(GAP_LEN - 1)) begin
                        gap_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                default: begin
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
